// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - shared types and defaults for the I$/D$ memory arbiter
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STARVE_W         = 4;

endpackage

// File: rtl/cache_mem_arbiter_starve.sv
// rtl/cache_mem_arbiter_starve.sv - saturating starvation counter with clear/increment/hold
import cache_mem_arbiter_pkg::*;

module rr_starve_counter #(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [STARVE_W-1:0] cnt_o
);

    localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one downstream memory port between I$ and D$, D$ first with bounded I$ starvation
import cache_mem_arbiter_pkg::*;

module cache_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                i_ren,
    input  logic                i_wen,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_byte_en,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_busy,
    output logic                i_error,
    input  logic                d_ren,
    input  logic                d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_byte_en,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_busy,
    output logic                d_error,
    output logic                m_ren,
    output logic                m_wen,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_byte_en,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_busy,
    input  logic                m_error,
    output logic                grant_i,
    output logic                grant_d
);

    localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt;
    logic                cnt_clr, cnt_inc;
    logic                i_act, d_act;
    logic                gnt_i, gnt_d;

    assign i_act = i_ren | i_wen;
    assign d_act = d_ren | d_wen;

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_act && (!d_act || (starve_cnt == LIMIT_V))) begin
                    state_d = GNT_I;
                    cnt_clr = 1'b1;
                end else if (d_act) begin
                    state_d = GNT_D;
                    cnt_inc = i_act;
                end
            end
            GNT_I, GNT_D: begin
                if (!m_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    rr_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .cnt_o (starve_cnt)
    );

    // Gating with RST drops the grant and quiets the downstream port in the reset cycle itself.
    assign gnt_i = (state_q == GNT_I) && !RST;
    assign gnt_d = (state_q == GNT_D) && !RST;

    assign grant_i   = gnt_i;
    assign grant_d   = gnt_d;
    assign m_ren     = (gnt_i & i_ren) | (gnt_d & d_ren);
    assign m_wen     = (gnt_i & i_wen) | (gnt_d & d_wen);
    assign m_addr    = gnt_i ? i_addr    : (gnt_d ? d_addr    : '0);
    assign m_wdata   = gnt_i ? i_wdata   : (gnt_d ? d_wdata   : '0);
    assign m_byte_en = gnt_i ? i_byte_en : (gnt_d ? d_byte_en : '0);

    assign i_busy  = gnt_i ? m_busy  : 1'b1;
    assign i_rdata = gnt_i ? m_rdata : '0;
    assign i_error = gnt_i & m_error & ~m_busy;
    assign d_busy  = gnt_d ? m_busy  : 1'b1;
    assign d_rdata = gnt_d ? m_rdata : '0;
    assign d_error = gnt_d & m_error & ~m_busy;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed vector table plus randomized traffic against a reference model
module tb_cache_mem_arbiter;

    localparam int LIMIT = 4;
    localparam logic [31:0] IWD = 32'h1111_2222;
    localparam logic [3:0]  IBE = 4'hF;
    localparam logic [31:0] DWD = 32'hA5A5_A5A5;
    localparam logic [3:0]  DBE = 4'b0011;

    logic        CLK, RST;
    logic        i_ren, i_wen, d_ren, d_wen;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [3:0]  i_byte_en, d_byte_en;
    logic [31:0] i_rdata, d_rdata;
    logic        i_busy, i_error, d_busy, d_error;
    logic        m_ren, m_wen;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_byte_en;
    logic        m_busy, m_error;
    logic        grant_i, grant_d;

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .i_ren(i_ren), .i_wen(i_wen), .i_addr(i_addr), .i_wdata(i_wdata), .i_byte_en(i_byte_en),
        .i_rdata(i_rdata), .i_busy(i_busy), .i_error(i_error),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_byte_en(d_byte_en),
        .d_rdata(d_rdata), .d_busy(d_busy), .d_error(d_error),
        .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_byte_en(m_byte_en),
        .m_rdata(m_rdata), .m_busy(m_busy), .m_error(m_error),
        .grant_i(grant_i), .grant_d(grant_d)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [139:0] act_v;
    assign act_v = {grant_i, grant_d, m_ren, m_wen, m_addr, m_wdata, m_byte_en,
                    i_rdata, i_busy, i_error, d_rdata, d_busy, d_error};

    int errors = 0;
    int checks = 0;

    function automatic logic [139:0] build(input logic gi, gd, mr, mw, input logic [31:0] ma, mwd,
                                           input logic [3:0] mbe, input logic [31:0] ird,
                                           input logic ib, ie, input logic [31:0] drd, input logic db, de);
        return {gi, gd, mr, mw, ma, mwd, mbe, ird, ib, ie, drd, db, de};
    endfunction

    task automatic check(input string name, input logic [139:0] got, input logic [139:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic rst, ir, iw; logic [31:0] ia;
        logic dr, dw; logic [31:0] da;
        logic mb; logic [31:0] mrd; logic me;
        logic egi, egd, emr, emw; logic [31:0] ema;
        logic eib, edb, eie, ede;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, ir, iw, input logic [31:0] ia,
                       input logic dr, dw, input logic [31:0] da,
                       input logic mb, input logic [31:0] mrd, input logic me,
                       input logic egi, egd, emr, emw, input logic [31:0] ema,
                       input logic eib, edb, eie, ede);
        vec_t v;
        v.rst = rst; v.ir = ir; v.iw = iw; v.ia = ia;
        v.dr = dr; v.dw = dw; v.da = da;
        v.mb = mb; v.mrd = mrd; v.me = me;
        v.egi = egi; v.egd = egd; v.emr = emr; v.emw = emw; v.ema = ema;
        v.eib = eib; v.edb = edb; v.eie = eie; v.ede = ede;
        tbl.push_back(v);
    endtask

    // Random-phase state: pending transactions per requester and the arbiter model.
    logic        ip, iw_r, dp, dw_r;
    int          owner;
    int          starve;
    logic [139:0] exp_v;

    initial begin
        RST = 1'b1;
        {i_ren, i_wen, d_ren, d_wen, m_busy, m_error} = '0;
        {i_addr, d_addr, m_rdata} = '0;
        i_wdata = IWD; i_byte_en = IBE; d_wdata = DWD; d_byte_en = DBE;

        // rst ir iw ia | dr dw da | mb mrd me | gi gd mr mw ma | ib db ie de
        add(1,0,0,0,       0,0,0,       1,0,0,             0,0,0,0,0,       1,1,0,0);
        add(0,1,0,'h100,   0,0,0,       1,0,0,             0,0,0,0,0,       1,1,0,0);
        for (int k = 0; k < 3; k++)
            add(0,1,0,'h100, 0,0,0,     1,0,0,             1,0,1,0,'h100,   1,1,0,0);
        add(0,1,0,'h100,   0,0,0,       0,'hDEADBEEF,0,    1,0,1,0,'h100,   0,1,0,0);
        add(0,0,0,0,       0,0,0,       1,0,0,             0,0,0,0,0,       1,1,0,0);
        add(0,1,0,'h200,   1,0,'h300,   1,0,0,             0,0,0,0,0,       1,1,0,0);
        add(0,1,0,'h200,   1,0,'h300,   0,'hCAFE0001,0,    0,1,1,0,'h300,   1,0,0,0);
        add(0,1,0,'h200,   0,0,0,       1,0,0,             0,0,0,0,0,       1,1,0,0);
        add(0,1,0,'h200,   0,0,0,       0,'h12345678,0,    1,0,1,0,'h200,   0,1,0,0);
        add(0,0,0,0,       0,0,0,       1,0,0,             0,0,0,0,0,       1,1,0,0);
        add(0,0,0,0,       0,1,'h400,   1,0,0,             0,0,0,0,0,       1,1,0,0);
        add(0,0,0,0,       0,1,'h400,   1,0,0,             0,1,0,1,'h400,   1,1,0,0);
        add(0,0,0,0,       0,1,'h400,   0,'h0BADF00D,0,    0,1,0,1,'h400,   1,0,0,0);
        add(0,0,0,0,       0,0,0,       1,0,0,             0,0,0,0,0,       1,1,0,0);
        add(0,1,0,'h500,   0,0,0,       1,0,0,             0,0,0,0,0,       1,1,0,0);
        add(0,1,0,'h500,   0,0,0,       1,0,1,             1,0,1,0,'h500,   1,1,0,0);
        add(0,1,0,'h500,   0,0,0,       0,'h55,1,          1,0,1,0,'h500,   0,1,1,0);
        add(0,0,0,0,       0,0,0,       0,0,1,             0,0,0,0,0,       1,1,0,0);
        add(0,0,0,0,       1,0,'h600,   1,0,0,             0,0,0,0,0,       1,1,0,0);
        add(0,0,0,0,       1,0,'h600,   1,0,0,             0,1,1,0,'h600,   1,1,0,0);
        add(1,0,0,0,       1,0,'h600,   1,0,0,             0,0,0,0,0,       1,1,0,0);
        add(0,0,0,0,       1,0,'h600,   1,0,0,             0,0,0,0,0,       1,1,0,0);
        add(0,0,0,0,       1,0,'h600,   0,0,0,             0,1,1,0,'h600,   1,0,0,0);
        add(0,0,0,0,       0,0,0,       1,0,0,             0,0,0,0,0,       1,1,0,0);
        for (int k = 0; k < LIMIT; k++) begin
            add(0,1,0,'h700, 1,0,32'h800+k, 1,0,0,         0,0,0,0,0,       1,1,0,0);
            add(0,1,0,'h700, 1,0,32'h800+k, 0,k,0,         0,1,1,0,32'h800+k, 1,0,0,0);
        end
        add(0,1,0,'h700,   1,0,'h900,   1,0,0,             0,0,0,0,0,       1,1,0,0);
        add(0,1,0,'h700,   1,0,'h900,   0,'h77,0,          1,0,1,0,'h700,   0,1,0,0);
        add(0,1,0,'h710,   1,0,'h900,   1,0,0,             0,0,0,0,0,       1,1,0,0);
        add(0,1,0,'h710,   1,0,'h900,   0,0,0,             0,1,1,0,'h900,   1,0,0,0);
        add(0,0,0,0,       0,0,0,       1,0,0,             0,0,0,0,0,       1,1,0,0);

        foreach (tbl[n]) begin
            @(posedge CLK); #1;
            RST = tbl[n].rst;
            i_ren = tbl[n].ir; i_wen = tbl[n].iw; i_addr = tbl[n].ia;
            d_ren = tbl[n].dr; d_wen = tbl[n].dw; d_addr = tbl[n].da;
            m_busy = tbl[n].mb; m_rdata = tbl[n].mrd; m_error = tbl[n].me;
            @(negedge CLK);
            check($sformatf("vec%0d", n), act_v,
                  build(tbl[n].egi, tbl[n].egd, tbl[n].emr, tbl[n].emw, tbl[n].ema,
                        tbl[n].egi ? IWD : (tbl[n].egd ? DWD : 32'h0),
                        tbl[n].egi ? IBE : (tbl[n].egd ? DBE : 4'h0),
                        tbl[n].egi ? tbl[n].mrd : 32'h0, tbl[n].eib, tbl[n].eie,
                        tbl[n].egd ? tbl[n].mrd : 32'h0, tbl[n].edb, tbl[n].ede));
        end

        // Randomized traffic: requesters hold each transaction until they observe busy low.
        ip = 1'b0; dp = 1'b0; iw_r = 1'b0; dw_r = 1'b0;
        owner = 0; starve = 0;
        @(posedge CLK); #1;
        RST = 1'b1; {i_ren, i_wen, d_ren, d_wen} = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge CLK); #1;
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1'b1; iw_r = ($urandom_range(0, 3) == 0);
                i_addr = $urandom; i_wdata = $urandom; i_byte_en = 4'($urandom_range(0, 15));
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1'b1; dw_r = ($urandom_range(0, 1) == 0);
                d_addr = $urandom; d_wdata = $urandom; d_byte_en = 4'($urandom_range(0, 15));
            end
            i_ren = ip & ~iw_r; i_wen = ip & iw_r;
            d_ren = dp & ~dw_r; d_wen = dp & dw_r;
            m_busy = ($urandom_range(0, 1) == 0);
            m_rdata = $urandom;
            m_error = ($urandom_range(0, 3) == 0);
            RST = ($urandom_range(0, 60) == 0);
            @(negedge CLK);

            case (RST ? 0 : owner)
                1: exp_v = build(1, 0, i_ren, i_wen, i_addr, i_wdata, i_byte_en,
                                 m_rdata, m_busy, m_error & ~m_busy, 32'h0, 1'b1, 1'b0);
                2: exp_v = build(0, 1, d_ren, d_wen, d_addr, d_wdata, d_byte_en,
                                 32'h0, 1'b1, 1'b0, m_rdata, m_busy, m_error & ~m_busy);
                default: exp_v = build(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            endcase
            check($sformatf("rand%0d", cyc), act_v, exp_v);

            if (RST) begin
                owner = 0; starve = 0;
            end else if (owner == 0) begin
                if (ip && dp) begin
                    if (starve == LIMIT) begin
                        owner = 1; starve = 0;
                    end else begin
                        owner = 2; starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
                    end
                end else if (ip) begin
                    owner = 1; starve = 0;
                end else if (dp) begin
                    owner = 2;
                end
            end else if (!m_busy) begin
                if (owner == 1) ip = 1'b0;
                else            dp = 1'b0;
                owner = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
